// File: rtl/store_arbiter.sv
// Two-port (CPU r/w, display read-only) arbiter onto a single strobe-driven store; ack lands READ_WAIT_CYCLES+1 / WRITE_PULSE_CYCLES+3 cycles after grant.
// Requesters hold req until ack; define STORE_ARB_ROUND_ROBIN_EN to alternate simultaneous grants, otherwise the CPU always wins.
module store_arbiter #(
    parameter int READ_WAIT_CYCLES   = 2,
    parameter int WRITE_PULSE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        disp_req,
    input  logic [4:0]  disp_addr,
    output logic        disp_ack,
    output logic [31:0] disp_rdata,
    output logic [4:0]  store_A,
    output logic [31:0] store_D,
    output logic        store_CS_n,
    output logic        store_WE_n,
    output logic        store_OE_n,
    input  logic [31:0] store_Q
);

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

    localparam logic [2:0] RD_LOAD = 3'(READ_WAIT_CYCLES - 1);
    localparam logic [2:0] WR_LOAD = 3'(WRITE_PULSE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  rd_cnt_q, rd_cnt_d;
    logic [2:0]  wr_cnt_q, wr_cnt_d;
    logic        gnt_disp_q, gnt_disp_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        cs_n_q, cs_n_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        disp_ack_q, disp_ack_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] disp_rdata_q, disp_rdata_d;
    logic        prefer_disp;
    logic        pick_disp;

`ifdef STORE_ARB_ROUND_ROBIN_EN
    logic last_disp_q, last_disp_d;

    assign prefer_disp = !last_disp_q;

    always_comb begin
        last_disp_d = last_disp_q;
        if (state_q == IDLE && (cpu_req || disp_req)) begin
            last_disp_d = pick_disp;
        end
    end

    // Last grant starts as display so the CPU wins the first contest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_disp_q <= 1'b1;
        end else begin
            last_disp_q <= last_disp_d;
        end
    end
`else
    assign prefer_disp = 1'b0;
`endif

    assign pick_disp = disp_req && (!cpu_req || prefer_disp);

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        gnt_disp_d   = gnt_disp_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cpu_rdata_d  = cpu_rdata_q;
        disp_rdata_d = disp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req || disp_req) begin
                    gnt_disp_d = pick_disp;
                    addr_d     = pick_disp ? disp_addr : cpu_addr;
                    if (!pick_disp && cpu_we) begin
                        data_d  = cpu_wdata;
                        state_d = WR_SETUP;
                    end else begin
                        rd_cnt_d = RD_LOAD;
                        state_d  = READ;
                    end
                end
            end
            READ: begin
                if (rd_cnt_q == 3'd0) begin
                    if (gnt_disp_q) begin
                        disp_rdata_d = store_Q;
                    end else begin
                        cpu_rdata_d = store_Q;
                    end
                    state_d = DONE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 3'd1;
                end
            end
            WR_SETUP: begin
                wr_cnt_d = WR_LOAD;
                state_d  = WR_PULSE;
            end
            WR_PULSE: begin
                if (wr_cnt_q == 3'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    wr_cnt_d = wr_cnt_q - 3'd1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and acks are registered, so decode them from the state being entered.
        cs_n_d     = (state_d == IDLE) || (state_d == DONE);
        oe_n_d     = (state_d != READ);
        we_n_d     = (state_d != WR_PULSE);
        cpu_ack_d  = (state_d == DONE) && !gnt_disp_d;
        disp_ack_d = (state_d == DONE) && gnt_disp_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rd_cnt_q     <= 3'd0;
            wr_cnt_q     <= 3'd0;
            gnt_disp_q   <= 1'b0;
            addr_q       <= 5'd0;
            data_q       <= 32'd0;
            cs_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            cpu_ack_q    <= 1'b0;
            disp_ack_q   <= 1'b0;
            cpu_rdata_q  <= 32'd0;
            disp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            gnt_disp_q   <= gnt_disp_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cs_n_q       <= cs_n_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            cpu_ack_q    <= cpu_ack_d;
            disp_ack_q   <= disp_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            disp_rdata_q <= disp_rdata_d;
        end
    end

    assign store_A    = addr_q;
    assign store_D    = data_q;
    assign store_CS_n = cs_n_q;
    assign store_WE_n = we_n_q;
    assign store_OE_n = oe_n_q;
    assign cpu_ack    = cpu_ack_q;
    assign disp_ack   = disp_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign disp_rdata = disp_rdata_q;

endmodule

// File: doc/store_arbiter.md
STORE_ARBITER -- requirements
Module: store_arbiter

Interface
REQ-001 The module SHALL have parameter READ_WAIT_CYCLES, default 2, giving the number of cycles (1..7) the store is held read-enabled before Q is captured.
REQ-002 The module SHALL have parameter WRITE_PULSE_CYCLES, default 2, giving the number of cycles (1..7) store_WE_n is held low per write.
REQ-003 The module SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-005 The module SHALL have the CPU request port: cpu_req in 1, cpu_we in 1 (1=write), cpu_addr in 5, cpu_wdata in 32, cpu_ack out 1, cpu_rdata out 32.
REQ-006 The module SHALL have the display request port: disp_req in 1, disp_addr in 5, disp_ack out 1, disp_rdata out 32; this port is read-only.
REQ-007 The module SHALL have the store-side port: store_A out 5, store_D out 32, store_CS_n out 1, store_WE_n out 1, store_OE_n out 1, store_Q in 32; all outputs are registered.

Function
REQ-008 The FSM SHALL have the states IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-009 IDLE SHALL drive CS_n, WE_n and OE_n high, and SHALL leave IDLE only when at least one req is high.
REQ-010 On leaving IDLE, the granted port's address, and for a CPU write its cpu_wdata, SHALL be latched into store_A and store_D; later req, address or data changes SHALL NOT affect the transaction.
REQ-011 Read path: IDLE->READ with CS_n=0, OE_n=0, WE_n=1 for exactly READ_WAIT_CYCLES cycles; store_Q is captured into the granted port's rdata at the last READ edge; then ->DONE.
REQ-012 Write path: WR_SETUP (1 cycle, CS_n=0, WE_n=1, OE_n=1) -> WR_PULSE (WRITE_PULSE_CYCLES cycles, WE_n=0) -> WR_HOLD (1 cycle, WE_n=1, CS_n=0) -> DONE.
REQ-013 While a transaction is in progress, WE_n and OE_n SHALL never be low together, and A/D SHALL be stable whenever WE_n is low.
REQ-014 DONE SHALL last 1 cycle, drive all strobes high, and pulse the granted port's ack high for exactly that cycle; DONE always goes ->IDLE.
REQ-015 Latency from the IDLE cycle that samples req to the ack cycle SHALL be READ_WAIT_CYCLES+1 cycles for a read and WRITE_PULSE_CYCLES+3 cycles for a write (defaults 3 and 5).
REQ-016 The rdata outputs SHALL hold their value until that port's next completed read.
REQ-017 The requester drops req on the edge that samples ack; there is a minimum of one IDLE cycle between transactions.
REQ-018 A req that is still high in IDLE after its ack SHALL start a new transaction, which is a legal back-to-back repeat.
REQ-019 Each counter SHALL be 3 bits wide, load parameter-1, and exit its state on reaching 0; no wrap-around is permitted.

Reset
REQ-020 Assertion of reset_n SHALL immediately force the state to IDLE, CS_n/WE_n/OE_n=1, both acks=0, store_A=0, store_D=0, both rdata=0, and the counters and last-grant to their reset values, even mid-write.
REQ-021 An aborted transaction SHALL NOT be acknowledged after reset is released.

Configuration
REQ-022 With STORE_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the port not granted last; last-grant resets to display, so the CPU wins first.
REQ-023 Without STORE_ARB_ROUND_ROBIN_EN, the CPU SHALL always win simultaneous requests (fixed priority), and the display may be starved.

Verification
REQ-024 After reset, a CPU write to addr 0x00 with data 0xDEADBEEF followed by a CPU read of 0x00 -> cpu_rdata=0xDEADBEEF, cpu_ack at write+5 and read+3 cycles, and WE_n low for exactly 2 cycles.
REQ-025 A display read of 0x1F after a CPU write of 0xCAFEBABE to 0x1F -> disp_rdata=0xCAFEBABE, disp_ack single-cycle, and cpu_ack never asserted.
REQ-026 Simultaneous cpu_req (read 0x01) and disp_req (read 0x02) held high for 3 transactions -> round-robin order CPU,DISP,CPU; fixed-priority order CPU,CPU,CPU.
REQ-027 reset_n pulsed low during WR_PULSE of a write of 0x12345678 to 0x05 -> strobes high immediately, no ack, and no X on any output.
REQ-028 A CPU write to 0x0A in which cpu_addr and cpu_wdata are changed to 0x0B and 0xBAADF00D after the grant -> 0x0A holds the original data and 0x0B is unchanged.
REQ-029 The bench SHALL assert in every cycle that WE_n and OE_n are never both low and that CS_n is high in IDLE and DONE.
